// File: rtl/approx_add_err_accum_if.sv
// rtl/approx_add_err_accum_if.sv - sample, control and result signals of the adder error accumulator
interface approx_add_err_accum_if #(
    parameter int W     = 16,
    parameter int LOG2N = 10
);
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            IN1;
    logic [W-1:0]            IN2;
    logic [W:0]              approx_sum;
    logic                    busy;
    logic                    res_valid;
    logic                    res_ready;
    logic [W+LOG2N:0]        sum_abs;
    logic [2*W+1+LOG2N:0]    sum_sq;
    logic [W:0]              max_abs;
    logic [LOG2N:0]          err_cnt;

    modport master (
        output start, in_valid, IN1, IN2, approx_sum, res_ready,
        input  in_ready, busy, res_valid, sum_abs, sum_sq, max_abs, err_cnt
    );

    modport slave (
        input  start, in_valid, IN1, IN2, approx_sum, res_ready,
        output in_ready, busy, res_valid, sum_abs, sum_sq, max_abs, err_cnt
    );
endinterface

// File: rtl/approx_add_err_accum.sv
// rtl/approx_add_err_accum.sv - error statistics (sum|e|, sum e^2, max|e|, nonzero count) for an approximate adder
module approx_add_err_accum #(
    parameter int W     = 16,
    parameter int LOG2N = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    approx_add_err_accum_if.slave  bus
);
    localparam int CW  = LOG2N + 1;
    localparam int SAW = W + 1 + LOG2N;
    localparam int SSW = 2 * W + 2 + LOG2N;
    localparam logic [CW-1:0] N_LAST = CW'((1 << LOG2N) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             in_ready_q;
    logic             busy_q;
    logic             res_valid_q;

    logic             v1;
    logic [W+1:0]     e1;
    logic             v2;
    logic [W:0]       abs2;
    logic [2*W+1:0]   sq2;
    logic             nz2;

    logic [SAW-1:0]   sum_abs_q;
    logic [SSW-1:0]   sum_sq_q;
    logic [W:0]       max_abs_q;
    logic [CW-1:0]    err_cnt_q;

    logic             hs;
    logic             acc_clr;
    logic [W:0]       exact_c;
    logic [W+1:0]     e_c;
    logic [W+1:0]     neg_e1;
    logic [W:0]       abs_c;
    logic [2*W+1:0]   sq_c;

    assign hs      = bus.in_valid & in_ready_q;
    assign acc_clr = (state == IDLE) & bus.start;

    // Exact sum is one bit wider than the operands; the error needs one more bit for its sign.
    assign exact_c = {1'b0, bus.IN1} + {1'b0, bus.IN2};
    assign e_c     = {1'b0, bus.approx_sum} - {1'b0, exact_c};
    assign neg_e1  = -e1;
    assign abs_c   = e1[W+1] ? neg_e1[W:0] : e1[W:0];
    assign sq_c    = {{(W+1){1'b0}}, abs_c} * {{(W+1){1'b0}}, abs_c};

    // Run control: counts accepted samples, waits for the pipeline to empty, then holds the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (hs) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == N_LAST) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!v1 && !v2) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Two pipeline stages: signed error, then magnitude, square and nonzero flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            e1   <= '0;
            v2   <= 1'b0;
            abs2 <= '0;
            sq2  <= '0;
            nz2  <= 1'b0;
        end else begin
            v1 <= hs;
            if (hs) begin
                e1 <= e_c;
            end
            v2 <= v1;
            if (v1) begin
                abs2 <= abs_c;
                sq2  <= sq_c;
                nz2  <= (e1 != '0);
            end
        end
    end

    // Accumulators are cleared by start and widened so a full run of worst-case samples cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_abs_q <= '0;
            sum_sq_q  <= '0;
            max_abs_q <= '0;
            err_cnt_q <= '0;
        end else if (acc_clr) begin
            sum_abs_q <= '0;
            sum_sq_q  <= '0;
            max_abs_q <= '0;
            err_cnt_q <= '0;
        end else if (v2) begin
            sum_abs_q <= sum_abs_q + SAW'(abs2);
            sum_sq_q  <= sum_sq_q + SSW'(sq2);
            if (abs2 > max_abs_q) begin
                max_abs_q <= abs2;
            end
            err_cnt_q <= err_cnt_q + CW'(nz2);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.sum_abs   = sum_abs_q;
    assign bus.sum_sq    = sum_sq_q;
    assign bus.max_abs   = max_abs_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_approx_add_err_accum.sv
// tb/tb_approx_add_err_accum.sv - randomized scoreboard bench for approx_add_err_accum
module tb_approx_add_err_accum;
    localparam int W     = 16;
    localparam int LOG2N = 2;
    localparam int N     = 1 << LOG2N;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] s;
    } smp_t;

    typedef struct {
        logic [18:0] sa;
        logic [35:0] ss;
        logic [16:0] ma;
        logic [2:0]  ec;
    } res_t;

    logic clk;
    logic rst;

    approx_add_err_accum_if #(.W(W), .LOG2N(LOG2N)) ifc ();

    approx_add_err_accum #(.W(W), .LOG2N(LOG2N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    smp_t smp_q[$];
    res_t exp_q[$];
    res_t last_exp;
    int   checks = 0;
    int   errors = 0;
    logic mon_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: statistics straight from the definition of the error, using integer arithmetic.
    function automatic res_t model();
        res_t   r;
        longint sa, ss, ma, ec, ex, e, ab;
        sa = 0; ss = 0; ma = 0; ec = 0;
        foreach (smp_q[i]) begin
            ex = longint'(smp_q[i].a) + longint'(smp_q[i].b);
            e  = longint'(smp_q[i].s) - ex;
            ab = (e < 0) ? -e : e;
            sa += ab;
            ss += ab * ab;
            if (ab > ma) ma = ab;
            if (e != 0) ec++;
        end
        r.sa = sa[18:0];
        r.ss = ss[35:0];
        r.ma = ma[16:0];
        r.ec = ec[2:0];
        return r;
    endfunction

    task automatic chk_outputs(input string tag, input res_t r);
        chk({tag, "_sum_abs"}, 64'(ifc.sum_abs), 64'(r.sa));
        chk({tag, "_sum_sq"},  64'(ifc.sum_sq),  64'(r.ss));
        chk({tag, "_max_abs"}, 64'(ifc.max_abs), 64'(r.ma));
        chk({tag, "_err_cnt"}, 64'(ifc.err_cnt), 64'(r.ec));
    endtask

    task automatic chk_ctrl(input string tag, input logic rdy, input logic bsy, input logic rv);
        chk({tag, "_in_ready"},  64'(ifc.in_ready),  64'(rdy));
        chk({tag, "_busy"},      64'(ifc.busy),      64'(bsy));
        chk({tag, "_res_valid"}, 64'(ifc.res_valid), 64'(rv));
    endtask

    // Monitor: the first cycle of each presented result is compared with the oldest expected result.
    always @(negedge clk) begin
        if (ifc.res_valid && !mon_seen) begin
            mon_seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(1), 64'(0));
            end else begin
                chk_outputs("result", exp_q.pop_front());
            end
        end else if (!ifc.res_valid) begin
            mon_seen = 1'b0;
        end
    end

    // Presents one sample and holds it until accepted; returns at posedge+1 after the handshake.
    task automatic send(input smp_t sm);
        int   k;
        logic hs;
        k  = 0;
        ifc.IN1        = sm.a;
        ifc.IN2        = sm.b;
        ifc.approx_sum = sm.s;
        ifc.in_valid   = 1'b1;
        do begin
            @(negedge clk);
            hs = ifc.in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!hs && k < 50);
        ifc.in_valid = 1'b0;
        if (!hs) chk("handshake_timeout", 64'(0), 64'(1));
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    // Full run over smp_q: random bubbles, optional result backpressure, then release to IDLE.
    task automatic do_run(input int gapmax, input int hold);
        int k;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, gapmax)) begin
                @(posedge clk);
                #1;
            end
            send(smp_q[i]);
            @(negedge clk);
            chk("in_ready_after_hs", 64'(ifc.in_ready), 64'((i == N - 1) ? 0 : 1));
            @(posedge clk);
            #1;
        end
        last_exp = model();
        exp_q.push_back(last_exp);
        k = 0;
        @(negedge clk);
        while (!ifc.res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", 64'(ifc.res_valid), 64'(1));
        for (int j = 0; j < hold; j++) begin
            @(posedge clk);
            #1;
            ifc.start    = (j == 5);
            ifc.in_valid = (j >= 5 && j < 10);
            @(negedge clk);
            chk_ctrl("hold", 1'b0, 1'b0, 1'b1);
            chk_outputs("hold", last_exp);
        end
        @(posedge clk);
        #1;
        ifc.in_valid  = 1'b0;
        ifc.res_ready = 1'b1;
        ifc.start     = 1'b1;
        @(posedge clk);
        #1;
        ifc.res_ready = 1'b0;
        ifc.start     = 1'b0;
        @(negedge clk);
        chk_ctrl("released", 1'b0, 1'b0, 1'b0);
        chk_outputs("released_hold", last_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
        smp_t sm;
        smp_q.delete();
        sm.a = a; sm.b = b; sm.s = s;
        for (int i = 0; i < N; i++) smp_q.push_back(sm);
    endtask

    task automatic fill_random();
        smp_t        sm;
        logic [16:0] ex;
        int          off;
        smp_q.delete();
        for (int i = 0; i < N; i++) begin
            sm.a = 16'($urandom);
            sm.b = 16'($urandom);
            ex   = {1'b0, sm.a} + {1'b0, sm.b};
            case ($urandom_range(0, 3))
                0: sm.s = ex;
                1: begin
                    off  = int'($urandom_range(0, 80)) - 40;
                    sm.s = 17'(int'(ex) + off);
                end
                2: sm.s = 17'($urandom);
                default: sm.s = ex ^ (17'd1 << $urandom_range(0, 16));
            endcase
            smp_q.push_back(sm);
        end
    endtask

    initial begin
        smp_t sm;
        res_t zero_r;
        zero_r = '{sa: '0, ss: '0, ma: '0, ec: '0};
        rst            = 1'b1;
        ifc.start      = 1'b0;
        ifc.in_valid   = 1'b0;
        ifc.res_ready  = 1'b0;
        ifc.IN1        = '0;
        ifc.IN2        = '0;
        ifc.approx_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_ctrl("idle", 1'b0, 1'b0, 1'b0);
            chk_outputs("idle", zero_r);
        end
        @(posedge clk);
        #1;

        fill_const(16'h0000, 16'h0000, 17'd31);
        do_run(0, 0);

        fill_const(16'h1234, 16'h0F0F, 17'h02143);
        do_run(3, 0);

        smp_q.delete();
        sm.a = 16'hFFFF; sm.b = 16'hFFFF; sm.s = 17'd0; smp_q.push_back(sm);
        sm.a = 16'h0000; sm.b = 16'h0000; sm.s = 17'd0; smp_q.push_back(sm);
        sm.a = 16'hFFFF; sm.b = 16'hFFFF; sm.s = 17'd0; smp_q.push_back(sm);
        sm.a = 16'h0000; sm.b = 16'h0000; sm.s = 17'd0; smp_q.push_back(sm);
        do_run(1, 20);

        fill_const(16'h0000, 16'h0000, 17'h1FFFF);
        pulse_start();
        send(smp_q[0]);
        send(smp_q[1]);
        rst = 1'b1;
        #2;
        chk_ctrl("abort", 1'b0, 1'b0, 1'b0);
        chk_outputs("abort", zero_r);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_ctrl("after_abort", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        fill_random();
        do_run(2, 0);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            do_run(2, (r == 3) ? 4 : 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
